ysyx_23060061_mdu: RTL and testbench
====================================

Name: ysyx_23060061_mdu

Overview:
- Iterative RV32M multiply/divide unit beside the single-cycle integer ALU in the NPC execute stage.
- Sequences one 33-bit add/subtract-and-shift datapath over 32 cycles to run the 8 M-extension ops.
- EXU stalls on the valid/ready handshake.
- Special divide cases (divide by zero, signed overflow) resolve in 1 cycle without iterating.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width, log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  abort in-flight op; synchronous
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1  input  WIDTH  rs1 value
- src2  input  WIDTH  rs2 value
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  op result

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, internal accumulators=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch op, the operand magnitudes (abs per signedness), and the result sign (neg_q/neg_r). The next state depends on the op:
  - op[2]=0 -> MUL.
  - op[2]=1 and src2==0 -> DONE, with quotient=all ones and remainder=src1.
  - Signed DIV/REM with src1=0x80000000 and src2=0xFFFFFFFF -> DONE, with quotient=0x80000000 and remainder=0.
  - Otherwise -> DIV.
- MUL:
  - 64-bit {hi,lo} product register, radix-2 shift-add, one multiplier bit per cycle, LSB first.
  - Counter runs 0..31; at 31 -> FIX.
- DIV:
  - Restoring division: shift {rem,quo} left 1.
  - Trial subtract rem - divisor in 33 bits. If non-negative, keep the difference and set the quotient LSB to 1. Otherwise restore and set it to 0.
  - Counter 0..31; at 31 -> FIX.
- FIX:
  - One cycle. Two's-complement negate the 64-bit product if the result sign is negative.
  - Negate the quotient by neg_q and the remainder by neg_r. neg_r follows the sign of the dividend.
  - Select the result: MUL -> low word; MULH/MULHSU/MULHU -> high word; DIV/DIVU -> quotient; REM/REMU -> remainder.
  - Register result, then -> DONE.
- DONE:
  - out_valid=1, result stable.
  - When out_ready=1 at an edge -> IDLE, out_valid=0.
  - in_ready=0 in DONE; there is no accept-while-completing.
- Latency:
  - Normal ops: accept edge N; out_valid high from cycle N+34 (32 iteration cycles + FIX + DONE entry).
  - Special divide cases: out_valid high at N+1.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL: low word is sign-independent; computed unsigned with no fixup needed but fixup harmless.
- flush:
  - Sync abort: next edge -> IDLE, out_valid=0, counter=0. Wins over every other transition, including in_valid in IDLE and out_ready in DONE.
- Back-pressure:
  - result and out_valid hold indefinitely while out_ready=0.
  - src1/src2/op changes after the accept edge have no effect.
- rst mid-operation:
  - Immediate return to reset values, regardless of state.
- Invariants:
  - in_ready and out_valid are never both 1.
  - in_ready=1 only in IDLE.

Decomposition:
- Shared package/header (ysyx_23060061 defines):
  - MDU op encodings: MDU_MUL..MDU_REMU.
  - State encodings: MDU_IDLE, MDU_MUL, MDU_DIV, MDU_FIX, MDU_DONE.
  - Constants: INT_MIN 32'h80000000, ALL_ONES.
- One natural sub-module: ysyx_23060061_mdu_step.
  - Combinational single iteration: 33-bit add/subtract plus shift for both MUL and DIV modes.
  - Keeps the FSM/counter file separate from the arithmetic.
- The parent instantiates the existing ysyx_23060061_MuxKey for the FIX result select.

Test Plan:
- MUL 7 x -3 (src2=0xFFFFFFFD): accept, out_valid exactly 34 cycles later, result=0xFFFFFFEB. MULHU same operands -> 0x00000006; MULH -> 0xFFFFFFFF.
- MULHSU src1=0xFFFFFFFF, src2=0xFFFFFFFF -> 0xFFFFFFFF. MULH 0x80000000 x 0x80000000 -> 0x40000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each at 34-cycle latency.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. All with out_valid 1 cycle after accept.
- Back-pressure and flush:
  - Hold out_ready=0 for 10 cycles: result stable, in_ready=0.
  - Assert flush at iteration 15: next cycle IDLE, in_ready=1, no out_valid.
  - A following MULHU 3x3 returns 0.
- Async reset: assert rst mid-DIV between clock edges. out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ysyx_23060061_mdu_pkg.sv
// ysyx_23060061_mdu_pkg: op/state encodings and constants shared by the multiply/divide unit
package ysyx_23060061_mdu_pkg;
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;
    typedef enum logic [2:0] {
        MDU_IDLE,
        MDU_MULS,
        MDU_DIVS,
        MDU_FIX,
        MDU_DONE
    } mdu_state_e;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
endpackage

// File: rtl/ysyx_23060061_mdu_if.sv
// ysyx_23060061_mdu_if: request/response handshake bundle between EXU and the multiply/divide unit
interface ysyx_23060061_mdu_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    modport master (output flush, in_valid, op, src1, src2, out_ready,
                    input  in_ready, out_valid, result);
    modport slave  (input  flush, in_valid, op, src1, src2, out_ready,
                    output in_ready, out_valid, result);
endinterface

// File: rtl/ysyx_23060061_MuxKey.sv
// ysyx_23060061_MuxKey: key-matched lookup mux; each lut entry is {key, data} with data in the low bits
module ysyx_23060061_MuxKey #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                    key_i,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut_i,
    output logic [DATA_LEN-1:0]                   out_o
);
    localparam int EW = KEY_LEN + DATA_LEN;
    always_comb begin
        out_o = '0;
        for (int i = 0; i < NR_KEY; i++)
            if (lut_i[i*EW+DATA_LEN +: KEY_LEN] == key_i) out_o = lut_i[i*EW +: DATA_LEN];
    end
endmodule

// File: rtl/ysyx_23060061_mdu_step.sv
// ysyx_23060061_mdu_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration
module ysyx_23060061_mdu_step #(parameter int WIDTH = 32) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH:0] a, b, sum;
    // divide shifts the next dividend bit into the partial remainder before the trial subtract
    assign a    = div_i ? {hi_i, lo_i[WIDTH-1]} : {1'b0, hi_i};
    assign b    = (div_i | lo_i[0]) ? {1'b0, opnd_i} : '0;
    assign sum  = div_i ? a - b : a + b;
    assign hi_o = div_i ? (sum[WIDTH] ? a[WIDTH-1:0] : sum[WIDTH-1:0]) : sum[WIDTH:1];
    assign lo_o = div_i ? {lo_i[WIDTH-2:0], ~sum[WIDTH]} : {sum[0], lo_i[WIDTH-1:1]};
endmodule

// File: rtl/ysyx_23060061_mdu.sv
// ysyx_23060061_mdu: iterative RV32M multiply/divide unit, 32 iterations plus a sign-fixup cycle
module ysyx_23060061_mdu
    import ysyx_23060061_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_23060061_mdu_if.slave     io
);
    mdu_state_e         state_q;
    mdu_op_e            op_q;
    logic [WIDTH-1:0]   hi_q, lo_q, opnd_q, result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q, neg_r, in_ready_q, out_valid_q;
    logic               s1_sgn, s2_sgn, a_neg, b_neg, div0, ovf;
    logic [WIDTH-1:0]   a_mag, b_mag, step_hi, step_lo, quo_f, rem_f, fix_res;
    logic [2*WIDTH-1:0] prod_f;
    logic [8*(3+WIDTH)-1:0] lut;
    assign s1_sgn = (io.op == MDU_MULH) | (io.op == MDU_MULHSU) | (io.op[2] & ~io.op[0]);
    assign s2_sgn = (io.op == MDU_MULH) | (io.op[2] & ~io.op[0]);
    assign a_neg  = s1_sgn & io.src1[WIDTH-1];
    assign b_neg  = s2_sgn & io.src2[WIDTH-1];
    assign a_mag  = a_neg ? -io.src1 : io.src1;
    assign b_mag  = b_neg ? -io.src2 : io.src2;
    assign div0   = io.op[2] & (io.src2 == '0);
    assign ovf    = io.op[2] & ~io.op[0] & (io.src1 == INT_MIN) & (io.src2 == ALL_ONES);
    ysyx_23060061_mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (state_q == MDU_DIVS),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );
    assign prod_f = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo_f  = neg_q ? -lo_q : lo_q;
    assign rem_f  = neg_r ? -hi_q : hi_q;
    assign lut = {MDU_MUL,  prod_f[WIDTH-1:0],       MDU_MULH,   prod_f[2*WIDTH-1:WIDTH],
                  MDU_MULHSU, prod_f[2*WIDTH-1:WIDTH], MDU_MULHU, prod_f[2*WIDTH-1:WIDTH],
                  MDU_DIV,  quo_f, MDU_DIVU, quo_f,   MDU_REM,    rem_f, MDU_REMU, rem_f};
    ysyx_23060061_MuxKey #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(WIDTH)) u_sel (
        .key_i (op_q),
        .lut_i (lut),
        .out_o (fix_res)
    );
    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MDU_IDLE;
            op_q        <= MDU_MUL;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (io.flush) begin
            state_q     <= MDU_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: if (io.in_valid) begin
                    op_q       <= mdu_op_e'(io.op);
                    neg_q      <= a_neg ^ b_neg;
                    neg_r      <= a_neg;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b0;
                    hi_q       <= '0;
                    lo_q       <= io.op[2] ? a_mag : b_mag;
                    opnd_q     <= io.op[2] ? b_mag : a_mag;
                    if (div0 | ovf) begin
                        result_q    <= div0 ? (io.op[1] ? io.src1 : ALL_ONES) : (io.op[1] ? '0 : INT_MIN);
                        out_valid_q <= 1'b1;
                        state_q     <= MDU_DONE;
                    end else begin
                        state_q <= io.op[2] ? MDU_DIVS : MDU_MULS;
                    end
                end
                MDU_MULS, MDU_DIVS: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= MDU_FIX;
                end
                MDU_FIX: begin
                    result_q    <= fix_res;
                    out_valid_q <= 1'b1;
                    state_q     <= MDU_DONE;
                end
                MDU_DONE: if (io.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= MDU_IDLE;
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060061_mdu.sv
// tb_ysyx_23060061_mdu: directed scoreboard bench for the iterative multiply/divide unit
module tb_ysyx_23060061_mdu;
    import ysyx_23060061_mdu_pkg::*;
    logic clk, rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    ysyx_23060061_mdu_if #(.WIDTH(32)) io ();
    ysyx_23060061_mdu #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .rst(rst), .io(io));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    always @(negedge clk) if (!rst) begin
        checks++;
        assert (!(io.in_ready === 1'b1 && io.out_valid === 1'b1)) else begin
            errors++;
            $error("FAIL invariant in_ready=%b out_valid=%b exp=not both", io.in_ready, io.out_valid);
        end
    end
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input int hold, input string tag);
        int n;
        logic [31:0] r0, e;
        logic stable;
        exp_q.push_back(res);
        lat_q.push_back(lat);
        @(negedge clk);
        io.op = op; io.src1 = a; io.src2 = b; io.in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.op = 3'($urandom); io.src1 = $urandom; io.src2 = $urandom;
        n = 1;
        while (io.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        e = exp_q.pop_front();
        check({tag, "_result"}, io.result, e);
        check({tag, "_latency"}, 32'(n), 32'(lat_q.pop_front()));
        r0 = io.result;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (io.result !== r0 || io.out_valid !== 1'b1 || io.in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 32'(stable), 32'd1);
        @(negedge clk); io.out_ready = 1'b1;
        @(posedge clk); #1; io.out_ready = 1'b0;
        check({tag, "_released"}, {30'd0, io.out_valid, io.in_ready}, 32'd1);
    endtask
    initial begin
        logic seen;
        rst = 1'b1;
        io.flush = 1'b0; io.in_valid = 1'b0; io.out_ready = 1'b0;
        io.op = 3'd0; io.src1 = '0; io.src2 = '0;
        #1;
        check("reset_in_ready", 32'(io.in_ready), 32'd1);
        check("reset_out_valid", 32'(io.out_valid), 32'd0);
        check("reset_result", io.result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_op(MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, "mul");
        do_op(MDU_MULHU,  32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 34, 0, "mulhu");
        do_op(MDU_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0, "mulh");
        do_op(MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, "mulhsu");
        do_op(MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 0, "mulh_min");
        do_op(MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 0, "div");
        do_op(MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 0, "rem");
        do_op(MDU_DIVU,   32'd100,        32'd7,         32'd14,        34, 0, "divu");
        do_op(MDU_REMU,   32'd100,        32'd7,         32'd2,         34, 10, "remu_bp");
        do_op(MDU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0, "div_by0");
        do_op(MDU_REMU,   32'd5,          32'd0,         32'd5,         1,  0, "remu_by0");
        do_op(MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0, "div_ovf");
        do_op(MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0, "rem_ovf");
        // flush partway through a divide
        @(negedge clk);
        io.op = MDU_DIVU; io.src1 = 32'd1000; io.src2 = 32'd3; io.in_valid = 1'b1;
        @(posedge clk); #1; io.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk); io.flush = 1'b1;
        @(posedge clk); #1; io.flush = 1'b0;
        check("flush_in_ready", 32'(io.in_ready), 32'd1);
        check("flush_out_valid", 32'(io.out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (io.out_valid === 1'b1) seen = 1'b1;
        end
        check("flush_no_result", 32'(seen), 32'd0);
        do_op(MDU_MULHU, 32'd3, 32'd3, 32'd0, 34, 0, "mulhu_after_flush");
        // asynchronous reset between edges
        @(negedge clk);
        io.op = MDU_DIV; io.src1 = 32'd77; io.src2 = 32'd5; io.in_valid = 1'b1;
        @(posedge clk); #1; io.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(io.in_ready), 32'd1);
        check("arst_out_valid", 32'(io.out_valid), 32'd0);
        check("arst_result", io.result, 32'd0);
        @(negedge clk); rst = 1'b0;
        do_op(MDU_DIV, 32'd77, 32'd5, 32'd15, 34, 0, "div_after_rst");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
